// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - bit-serial a - b - bin subtractor, LSB first (optional SUB_OVERFLOW_EN adds ovf)
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // One full-subtractor cell; on the last bit ai/bi are the operand MSBs.
  always_comb begin
    ai       = a_sh[0];
    bi       = b_sh[0];
    d        = ai ^ bi ^ br;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    res_next = {d, res_sh[WIDTH-1:1]};
    last     = (cnt == LAST);
  end

  // Control FSM plus operand/result shift registers; outputs load only on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff  <= res_next;
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SUB_OVERFLOW_EN
            ovf   <= (ai != bi) && (d != ai);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - self-checking bench for serial_subtractor_8bit
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] diff;
  logic       bout;
  logic       busy;
  logic       done;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int total = 0;
  int passed = 0;

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return 8'(r & 255);
  endfunction

  function automatic logic ref_bout(input logic [7:0] x, input logic [7:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [7:0] r;
    r = ref_diff(x, y, c);
    return (x[7] != y[7]) && (r[7] != x[7]);
  endfunction

  // Issue one operation, scramble inputs after acceptance, report latency and diff stability.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       output int lat, output logic stable);
    logic [7:0] d0;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    d0 = diff;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = -1;
    stable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (diff !== d0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    total++;
    if ({diff, bout, busy, done} !== 11'd0)
      $display("FAIL reset_outputs: got diff=%h bout=%b busy=%b done=%b expected all 0", diff, bout, busy, done);
    else passed++;
  endtask

  task automatic test_vectors();
    int lat; logic st;
    do_op(8'h00, 8'h00, 1'b1, lat, st);
    total++;
    if (lat !== 8 || diff !== 8'hFF || bout !== 1'b1)
      $display("FAIL vec_00_00_1: got lat=%0d diff=%h bout=%b expected lat=8 diff=ff bout=1", lat, diff, bout);
    else passed++;
`ifdef SUB_OVERFLOW_EN
    total++;
    if (ovf !== 1'b0) $display("FAIL vec_00_00_1_ovf: got %b expected 0", ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_timing();
    int bad_busy = 0, bad_done = 0;
    a = 8'hFF; b = 8'hFF; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      tick();
    end
    total++;
    if (bad_busy != 0 || bad_done != 0)
      $display("FAIL timing_shift: got %0d busy-low and %0d early-done cycles expected 0 and 0", bad_busy, bad_done);
    else passed++;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h00 || bout !== 1'b0)
      $display("FAIL timing_done: got done=%b busy=%b diff=%h bout=%b expected 1 0 00 0", done, busy, diff, bout);
    else passed++;
`ifdef SUB_OVERFLOW_EN
    total++;
    if (ovf !== 1'b0) $display("FAIL timing_ovf: got %b expected 0", ovf); else passed++;
`endif
    tick();
    total++;
    if (done !== 1'b0 || diff !== 8'h00)
      $display("FAIL done_one_cycle: got done=%b diff=%h expected 0 00", done, diff);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic st;
    do_op(8'hAA, 8'hFF, 1'b1, lat, st);
    total++;
    if (lat !== 8 || diff !== 8'hAA || bout !== 1'b1)
      $display("FAIL b2b_first: got lat=%0d diff=%h bout=%b expected 8 aa 1", lat, diff, bout);
    else passed++;
    do_op(8'h80, 8'h01, 1'b0, lat, st);
    total++;
    if (lat !== 8 || diff !== 8'h7F || bout !== 1'b0 || st !== 1'b1)
      $display("FAIL b2b_second: got lat=%0d diff=%h bout=%b stable=%b expected 8 7f 0 1", lat, diff, bout, st);
    else passed++;
`ifdef SUB_OVERFLOW_EN
    total++;
    if (ovf !== 1'b1) $display("FAIL b2b_second_ovf: got %b expected 1", ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_ignore_start();
    int pulses = 0, first = -1;
    a = 8'hBB; b = 8'hAE; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3 || i == 5) begin
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      end else start = 1'b0;
      tick();
      if (done) begin pulses++; if (first < 0) first = i; end
    end
    start = 1'b0;
    total++;
    if (first !== 8 || diff !== 8'h0D || bout !== 1'b0)
      $display("FAIL ignore_start_result: got done_at=%0d diff=%h bout=%b expected 8 0d 0", first, diff, bout);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
    end
    total++;
    if (pulses !== 1) $display("FAIL ignore_start_pulses: got %0d expected 1", pulses); else passed++;
  endtask

  task automatic test_reset_abort();
    int pulses = 0, lat; logic st;
    logic [7:0] held;
    held = diff;
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (done) pulses++;
    end
    total++;
    if (diff !== held) $display("FAIL abort_hold: got diff=%h expected %h", diff, held); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      tick();
    end
    total++;
    if (pulses !== 0 || {diff, bout, busy, done} !== 11'd0)
      $display("FAIL abort_outputs: got pulses=%0d diff=%h bout=%b busy=%b done=%b expected 0 00 0 0 0",
               pulses, diff, bout, busy, done);
    else passed++;
`ifdef SUB_OVERFLOW_EN
    total++;
    if (ovf !== 1'b0) $display("FAIL abort_ovf: got %b expected 0", ovf); else passed++;
`endif
    do_op(8'hD5, 8'h9D, 1'b1, lat, st);
    total++;
    if (lat !== 8 || diff !== 8'h37 || bout !== 1'b0)
      $display("FAIL after_reset: got lat=%0d diff=%h bout=%b expected 8 37 0", lat, diff, bout);
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int lat; logic st;
    logic [7:0] ra, rb; logic rc;
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      if (n == 0) begin ra = 8'h00; rb = 8'hFF; rc = 1'b1; end
      if (n == 1) begin ra = 8'hFF; rb = 8'h00; rc = 1'b0; end
      do_op(ra, rb, rc, lat, st);
      total++;
      if (lat !== 8 || st !== 1'b1 || diff !== ref_diff(ra, rb, rc) || bout !== ref_bout(ra, rb, rc))
        $display("FAIL random_%0d: a=%h b=%h bin=%b got lat=%0d stable=%b diff=%h bout=%b expected 8 1 %h %b",
                 n, ra, rb, rc, lat, st, diff, bout, ref_diff(ra, rb, rc), ref_bout(ra, rb, rc));
      else passed++;
`ifdef SUB_OVERFLOW_EN
      total++;
      if (ovf !== ref_ovf(ra, rb, rc))
        $display("FAIL random_ovf_%0d: got %b expected %b", n, ovf, ref_ovf(ra, rb, rc));
      else passed++;
`endif
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_vectors();
    test_timing();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
